// File: rtl/mul_accumulator.sv
// Purpose: sums a block of LEN multiplier products into a saturating accumulator, sticky sat/ovf flags.
// Latency: block result is presented one cycle after the transfer that completes the block.
// Backpressure: in_ready drops in IDLE/DONE; the result holds in DONE until out_ready, then two bubble cycles.
module mul_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             prod_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             sat,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int               SUM_W   = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_r;
  logic             ovf_r;

  logic             xfer;
  logic             hs;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake qualifiers and the one-bit-wider sum used to detect saturation.
  always_comb begin
    xfer    = in_valid && (state == ACCUM);
    hs      = out_ready && (state == DONE);
    sum     = {1'b0, acc} + SUM_W'(prod);
    cnt_inc = cnt + CNT_W'(1);
  end

  // Next-state logic; clear overrides every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ACCUM;
      ACCUM:   if (xfer && (cnt_inc == LEN_C)) state_nxt = DONE;
      DONE:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accumulator, counter and sticky flags; zeroed whenever a block ends or is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (clear || (state == IDLE) || hs) begin
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (xfer) begin
      if (sum[ACC_W]) begin
        acc   <= ACC_MAX;
        sat_r <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
      ovf_r <= ovf_r | prod_ovf;
      cnt   <= cnt_inc;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign sat       = sat_r;
  assign ovf       = ovf_r;
  assign count     = cnt;

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: two instances (16-bit/LEN 8 and 9-bit/LEN 4), cycle model plus literal checks.
// Inputs driven on falling edges, outputs compared on falling edges against the block-level model.
// Covers saturation, sticky ovf, gaps, output stall, clear and asynchronous reset.
module tb_mul_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv[2];
  logic       clr[2];
  logic       io[2];
  logic       ordy[2];
  logic [7:0] pr[2];
  logic       ir[2];
  logic       ov[2];
  logic       st[2];
  logic       of[2];
  logic [7:0] cn[2];
  logic [15:0] res0;
  logic [8:0]  res1;

  mul_accumulator #(.ACC_W(16), .LEN(8), .CNT_W(8)) d0 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .prod(pr[0]), .prod_ovf(io[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res0), .sat(st[0]), .ovf(of[0]), .count(cn[0])
  );

  mul_accumulator #(.ACC_W(9), .LEN(4), .CNT_W(8)) d1 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .prod(pr[1]), .prod_ovf(io[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res1), .sat(st[1]), .ovf(of[1]), .count(cn[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint lmax(input int d);
    return (d == 0) ? 64'd65535 : 64'd511;
  endfunction

  function automatic int llen(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  function automatic longint getres(input int d);
    return (d == 0) ? longint'(res0) : longint'(res1);
  endfunction

  // Block-level model: bubble cycles remaining, products taken, exact sum, ovf seen.
  int     m_wait[2];
  int     m_n[2];
  longint m_sum[2];
  bit     m_ovf[2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_wait[d] = 1; m_n[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
      end else if (clr[d]) begin
        m_wait[d] = 1; m_n[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
      end else if (m_wait[d] == 0 && m_n[d] == llen(d)) begin
        if (ordy[d]) begin
          m_wait[d] = 1; m_n[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
        end
      end else if (m_wait[d] > 0) begin
        m_wait[d] = m_wait[d] - 1;
      end else if (iv[d]) begin
        m_n[d]   = m_n[d] + 1;
        m_sum[d] = m_sum[d] + longint'(pr[d]);
        m_ovf[d] = m_ovf[d] | io[d];
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit     e_rdy, e_ov;
      longint e_res;
      e_rdy = (m_wait[d] == 0) && (m_n[d] < llen(d));
      e_ov  = (m_wait[d] == 0) && (m_n[d] == llen(d));
      e_res = (m_sum[d] > lmax(d)) ? lmax(d) : m_sum[d];
      chk($sformatf("d%0d.in_ready", d), ir[d], e_rdy);
      chk($sformatf("d%0d.out_valid", d), ov[d], e_ov);
      chk($sformatf("d%0d.count", d), cn[d], m_n[d]);
      chk($sformatf("d%0d.sat", d), st[d], m_sum[d] > lmax(d));
      chk($sformatf("d%0d.ovf", d), of[d], m_ovf[d]);
      if (e_ov) chk($sformatf("d%0d.result", d), getres(d), e_res);
    end
  end

  int blk_p[16];
  bit blk_o[16];

  task automatic set_blk(input int n, input int base, input int step, input int ovf_idx);
    for (int i = 0; i < n; i++) begin
      blk_p[i] = base + step * i;
      blk_o[i] = (i == ovf_idx);
    end
  endtask

  // Offer products until n are accepted; clr_at fires clear with that transfer.
  task automatic feed(input int d, input int n, input bit gaps, input int clr_at);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      pr[d] = 8'(blk_p[k]);
      io[d] = blk_o[k];
      iv[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (clr_at == k && ir[d] && iv[d]) begin
        clr[d] = 1'b1;
        k = n;
      end else if (iv[d] && ir[d]) begin
        k++;
      end
    end
    if (guard >= 1000) chk("feed_timeout", 0, 1);
  endtask

  // Wait for the result, check literal values across the stall, then the two bubble cycles.
  task automatic finish_blk(input int d, input int hold, input bit keep_valid, input longint er,
                            input int es, input int eo, input bit tight);
    int waitc = 0;
    @(negedge clk);
    if (!keep_valid) iv[d] = 1'b0;
    while (!ov[d] && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) chk("done_timeout", 0, 1);
    if (tight) chk("latency", waitc, 0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("lit_result", getres(d), er);
      chk("lit_sat", st[d], es);
      chk("lit_ovf", of[d], eo);
      chk("lit_count", cn[d], llen(d));
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", ov[d], 0);
    chk("idle_in_ready", ir[d], 0);
    chk("idle_count", cn[d], 0);
    @(negedge clk);
    chk("resume_in_ready", ir[d], 1);
  endtask

  task automatic zero_check(input string tag);
    #1;
    chk({tag, "_in_ready"}, ir[0], 0);
    chk({tag, "_out_valid"}, ov[0], 0);
    chk({tag, "_result"}, res0, 0);
    chk({tag, "_count"}, cn[0], 0);
    chk({tag, "_sat"}, st[0], 0);
    chk({tag, "_ovf"}, of[0], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; clr[d] = 0; io[d] = 0; ordy[d] = 1; pr[d] = 0;
      m_wait[d] = 1; m_n[d] = 0; m_sum[d] = 0; m_ovf[d] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    zero_check("reset");
    #1 rst_n = 1'b1;

    // Products 1..8 -> 36
    set_blk(8, 1, 1, -1);
    feed(0, 8, 0, -1);
    finish_blk(0, 0, 0, 36, 0, 0, 1);

    // 9-bit saturation: 200,200,200,5 -> 511, sat
    blk_p[0] = 200; blk_p[1] = 200; blk_p[2] = 200; blk_p[3] = 5;
    for (int i = 0; i < 4; i++) blk_o[i] = 0;
    feed(1, 4, 0, -1);
    finish_blk(1, 0, 0, 511, 1, 0, 1);

    // Sticky ovf on second product: 10,20,30,40 -> 100
    set_blk(4, 10, 10, 1);
    feed(1, 4, 0, -1);
    finish_blk(1, 0, 0, 100, 0, 1, 1);

    // Random gaps and a stalled output with in_valid still asserted
    blk_p[0] = 3;  blk_p[1] = 5;  blk_p[2] = 7;  blk_p[3] = 11;
    blk_p[4] = 13; blk_p[5] = 17; blk_p[6] = 19; blk_p[7] = 23;
    for (int i = 0; i < 8; i++) blk_o[i] = (i == 7);
    ordy[0] = 1'b0;
    feed(0, 8, 1, -1);
    iv[0] = 1'b1;
    finish_blk(0, 5, 1, 98, 0, 1, 0);

    // Clear together with the fifth transfer, then a clean 8x9 block
    set_blk(8, 9, 0, -1);
    feed(0, 8, 0, 4);
    @(negedge clk);
    clr[0] = 1'b0;
    iv[0]  = 1'b0;
    chk("clear_out_valid", ov[0], 0);
    chk("clear_count", cn[0], 0);
    feed(0, 8, 0, -1);
    finish_blk(0, 0, 0, 72, 0, 0, 1);

    // Asynchronous reset mid-block
    set_blk(8, 1, 1, -1);
    feed(0, 3, 0, -1);
    @(negedge clk);
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    zero_check("rst_mid");
    @(negedge clk);
    #2 rst_n = 1'b1;
    feed(0, 8, 0, -1);
    finish_blk(0, 0, 0, 36, 0, 0, 1);

    // Asynchronous reset while the result waits in DONE
    set_blk(8, 250, 0, -1);
    ordy[0] = 1'b0;
    feed(0, 8, 0, -1);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("done_before_rst", ov[0], 1);
    chk("done_result", res0, 2000);
    #2 rst_n = 1'b0;
    zero_check("rst_done");
    @(negedge clk);
    #2 rst_n = 1'b1;
    ordy[0] = 1'b1;
    set_blk(8, 1, 1, -1);
    feed(0, 8, 0, -1);
    finish_blk(0, 0, 0, 36, 0, 0, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
